// File: rtl/rom_arbiter_if.sv
// Core-side request/response bundle for rom_arbiter: two request ports sharing one
// registered response bus. master = core clients, slave = arbiter.
interface rom_arbiter_if #(
   parameter int AW    = 3,
   parameter int EXTRA = 4
);
   localparam int DW = (2 ** EXTRA) * 8;

   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [AW:0]      req_addr0;
   logic [AW:0]      req_addr1;
   logic [EXTRA-1:0] req_extra0;
   logic [EXTRA-1:0] req_extra1;
   logic [AW:0]      bound_lo0;
   logic [AW:0]      bound_hi0;
   logic [AW:0]      bound_lo1;
   logic [AW:0]      bound_hi1;
   logic [1:0]       resp_valid;
   logic [1:0]       resp_ready;
   logic [DW-1:0]    resp_data;
   logic             resp_error;

   modport master (
      output req_valid, req_addr0, req_addr1, req_extra0, req_extra1,
             bound_lo0, bound_hi0, bound_lo1, bound_hi1, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_error
   );

   modport slave (
      input  req_valid, req_addr0, req_addr1, req_extra0, req_extra1,
             bound_lo0, bound_hi0, bound_lo1, bound_hi1, resp_ready,
      output req_ready, resp_valid, resp_data, resp_error
   );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of the single genrom read port, one access in flight.
// ROM_ARB_RR_EN defined: round-robin between ports; undefined: port 0 fixed priority.
module rom_arbiter #(
   parameter int AW    = 3,
   parameter int EXTRA = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   rom_arbiter_if.slave                  bus,
   output logic [AW:0]                   mem_addr,
   output logic [EXTRA-1:0]              mem_extra,
   output logic [AW:0]                   mem_lower_bound,
   output logic [AW:0]                   mem_upper_bound,
   input  logic [((2 ** EXTRA) * 8)-1:0] mem_data,
   input  logic                          mem_error
);
   localparam int DW = (2 ** EXTRA) * 8;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t        state;
   state_t        state_nxt;
   logic          grant;
   logic          win;
   logic          xfer;
   logic [1:0]    req_ready;
   logic [1:0]    resp_valid;
   logic [DW-1:0] resp_data_q;
   logic          resp_error_q;
`ifdef ROM_ARB_RR_EN
   logic          last_served;
`endif

   // The winner is always a requesting port, so any valid request in IDLE transfers.
   always_comb begin
`ifdef ROM_ARB_RR_EN
      win = (bus.req_valid == 2'b11) ? ~last_served : ~bus.req_valid[0];
`else
      win = ~bus.req_valid[0];
`endif
   end

   always_comb begin
      state_nxt  = state;
      req_ready  = '0;
      resp_valid = '0;
      xfer       = 1'b0;
      case (state)
         IDLE: begin
            if (|bus.req_valid) begin
               req_ready[win] = 1'b1;
               xfer           = 1'b1;
               state_nxt      = ADDR;
            end
         end
         ADDR: state_nxt = DATA;
         DATA: state_nxt = RESP;
         RESP: begin
            resp_valid[grant] = 1'b1;
            if (bus.resp_ready[grant]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.req_ready  = req_ready;
   assign bus.resp_valid = resp_valid;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_error = resp_error_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         grant           <= 1'b0;
         mem_addr        <= '0;
         mem_extra       <= '0;
         mem_lower_bound <= '0;
         mem_upper_bound <= '0;
         resp_data_q     <= '0;
         resp_error_q    <= 1'b0;
`ifdef ROM_ARB_RR_EN
         last_served     <= 1'b1;
`endif
      end else begin
         state <= state_nxt;
         if (xfer) begin
            grant           <= win;
            mem_addr        <= win ? bus.req_addr1  : bus.req_addr0;
            mem_extra       <= win ? bus.req_extra1 : bus.req_extra0;
            mem_lower_bound <= win ? bus.bound_lo1  : bus.bound_lo0;
            mem_upper_bound <= win ? bus.bound_hi1  : bus.bound_hi0;
`ifdef ROM_ARB_RR_EN
            last_served     <= win;
`endif
         end
         // ROM output is valid in DATA, one cycle after it sampled the ADDR-cycle address.
         if (state == DATA) begin
            resp_data_q  <= mem_data;
            resp_error_q <= mem_error;
         end
      end
   end
endmodule

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter with a small registered ROM model
// (byte k = 0xA0+k, extra field echoed in bits 11:8, error when addr is outside the window).
module tb_rom_arbiter;
   localparam int AW    = 3;
   localparam int EXTRA = 4;
   localparam int DW    = (2 ** EXTRA) * 8;

   logic              clk;
   logic              reset;
   logic [AW:0]       mem_addr;
   logic [EXTRA-1:0]  mem_extra;
   logic [AW:0]       mem_lower_bound;
   logic [AW:0]       mem_upper_bound;
   logic [DW-1:0]     mem_data;
   logic              mem_error;
   int                total;
   int                bad;

   rom_arbiter_if #(.AW(AW), .EXTRA(EXTRA)) bus ();

   rom_arbiter #(.AW(AW), .EXTRA(EXTRA)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .mem_addr(mem_addr), .mem_extra(mem_extra),
      .mem_lower_bound(mem_lower_bound), .mem_upper_bound(mem_upper_bound),
      .mem_data(mem_data), .mem_error(mem_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      mem_data  <= {{(DW-16){1'b0}}, 4'h0, mem_extra, 8'hA0 + {4'h0, mem_addr}};
      mem_error <= (mem_addr < mem_lower_bound) || (mem_addr > mem_upper_bound);
   end

   task automatic idle_inputs();
      bus.req_valid  = 2'b00;
      bus.resp_ready = 2'b00;
      bus.req_addr0  = '0;
      bus.req_addr1  = '0;
      bus.req_extra0 = '0;
      bus.req_extra1 = '0;
      bus.bound_lo0  = 4'd0;
      bus.bound_hi0  = 4'd15;
      bus.bound_lo1  = 4'd0;
      bus.bound_hi1  = 4'd15;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      total++; if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL reset_resp_valid got=%b want=00", bus.resp_valid); end
      total++; if (bus.resp_data !== '0) begin bad++; $display("FAIL reset_resp_data got=%h want=0", bus.resp_data); end
      total++; if (bus.resp_error !== 1'b0) begin bad++; $display("FAIL reset_resp_error got=%b want=0", bus.resp_error); end
      total++; if ({mem_addr, mem_extra, mem_lower_bound, mem_upper_bound} !== '0)
         begin bad++; $display("FAIL reset_mem got=%h/%h/%h/%h want=0/0/0/0", mem_addr, mem_extra, mem_lower_bound, mem_upper_bound); end
      bus.req_valid = 2'b11;
      #1;
      total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL reset_first_grant got=%b want=01", bus.req_ready); end
      bus.req_valid = 2'b00;
   endtask

   task automatic test_single();
      @(negedge clk);
      bus.req_valid = 2'b01; bus.req_addr0 = 4'd2; bus.req_extra0 = 4'd0;
      #1;
      total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL single_req_ready got=%b want=01", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 2'b00;
      total++; if (mem_addr !== 4'd2) begin bad++; $display("FAIL single_mem_addr got=%0d want=2", mem_addr); end
      total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL single_ready_busy got=%b want=00", bus.req_ready); end
      @(negedge clk);
      total++; if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL single_early_valid got=%b want=00", bus.resp_valid); end
      @(negedge clk);
      total++; if (bus.resp_valid !== 2'b01) begin bad++; $display("FAIL single_resp_valid got=%b want=01", bus.resp_valid); end
      total++; if (bus.resp_data !== 128'hA2) begin bad++; $display("FAIL single_resp_data got=%h want=a2", bus.resp_data); end
      total++; if (bus.resp_error !== 1'b0) begin bad++; $display("FAIL single_resp_error got=%b want=0", bus.resp_error); end
      bus.resp_ready = 2'b01;
      @(negedge clk);
      bus.resp_ready = 2'b00;
      total++; if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL single_consumed got=%b want=00", bus.resp_valid); end
   endtask

   task automatic test_bounds();
      bus.req_valid = 2'b10; bus.req_addr1 = 4'd1; bus.req_extra1 = 4'd2;
      bus.bound_lo1 = 4'd4;  bus.bound_hi1 = 4'd7;
      #1;
      total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL bounds_req_ready got=%b want=10", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 2'b00;
      total++; if ({mem_lower_bound, mem_upper_bound} !== {4'd4, 4'd7})
         begin bad++; $display("FAIL bounds_window got=%0d..%0d want=4..7", mem_lower_bound, mem_upper_bound); end
      total++; if ({mem_addr, mem_extra} !== {4'd1, 4'd2}) begin bad++; $display("FAIL bounds_addr got=%0d/%0d want=1/2", mem_addr, mem_extra); end
      repeat (2) @(negedge clk);
      total++; if (bus.resp_valid !== 2'b10) begin bad++; $display("FAIL bounds_resp_valid got=%b want=10", bus.resp_valid); end
      total++; if (bus.resp_error !== 1'b1) begin bad++; $display("FAIL bounds_resp_error got=%b want=1", bus.resp_error); end
      total++; if (bus.resp_data !== 128'h2A1) begin bad++; $display("FAIL bounds_resp_data got=%h want=2a1", bus.resp_data); end
      bus.resp_ready = 2'b10;
      @(negedge clk);
      bus.resp_ready = 2'b00;
      idle_inputs();
   endtask

   task automatic test_hold();
      bus.req_valid = 2'b01; bus.req_addr0 = 4'd5; bus.req_extra0 = 4'd1;
      repeat (3) @(negedge clk);
      bus.req_valid = 2'b11;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 128'h1A5 || bus.req_ready !== 2'b00)
            begin bad++; $display("FAIL hold_cycle%0d got=%b/%h/%b want=01/1a5/00", i, bus.resp_valid, bus.resp_data, bus.req_ready); end
         @(negedge clk);
      end
      bus.resp_ready = 2'b01;
      @(negedge clk);
      bus.resp_ready = 2'b00;
      bus.req_valid  = 2'b01;
      #1;
      total++; if (bus.resp_valid !== 2'b00 || bus.req_ready !== 2'b01)
         begin bad++; $display("FAIL hold_release got=%b/%b want=00/01", bus.resp_valid, bus.req_ready); end
      bus.req_valid = 2'b00;
      idle_inputs();
   endtask

   task automatic test_latch();
      @(negedge clk);
      bus.req_valid = 2'b01; bus.req_addr0 = 4'd3; bus.req_extra0 = 4'd0;
      bus.bound_lo0 = 4'd2;  bus.bound_hi0 = 4'd4;
      @(negedge clk);
      bus.req_valid = 2'b00;
      bus.req_addr0 = 4'd9;  bus.req_extra0 = 4'd3;
      bus.bound_lo0 = 4'd10; bus.bound_hi0 = 4'd12;
      #1;
      total++; if ({mem_addr, mem_extra, mem_lower_bound, mem_upper_bound} !== {4'd3, 4'd0, 4'd2, 4'd4})
         begin bad++; $display("FAIL latch_mem got=%0d/%0d/%0d/%0d want=3/0/2/4", mem_addr, mem_extra, mem_lower_bound, mem_upper_bound); end
      repeat (2) @(negedge clk);
      total++; if (bus.resp_data !== 128'hA3 || bus.resp_error !== 1'b0)
         begin bad++; $display("FAIL latch_resp got=%h/%b want=a3/0", bus.resp_data, bus.resp_error); end
      bus.resp_ready = 2'b01;
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_grant [4];
`ifdef ROM_ARB_RR_EN
      exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      exp_grant = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus.req_addr0 = 4'd0; bus.req_addr1 = 4'd8;
      bus.req_valid = 2'b11; bus.resp_ready = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (bus.req_ready !== exp_grant[i]) begin bad++; $display("FAIL b2b_grant%0d got=%b want=%b", i, bus.req_ready, exp_grant[i]); end
         repeat (3) @(negedge clk);
         total++; if (bus.resp_valid !== exp_grant[i] || bus.resp_data !== (exp_grant[i][1] ? 128'hA8 : 128'hA0))
            begin bad++; $display("FAIL b2b_resp%0d got=%b/%h want=%b", i, bus.resp_valid, bus.resp_data, exp_grant[i]); end
         @(negedge clk);
      end
      idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      bus.req_valid = 2'b01; bus.req_addr0 = 4'd6; bus.req_extra0 = 4'd1;
      @(negedge clk);
      bus.req_valid = 2'b00;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++; if (bus.resp_valid !== 2'b00 || bus.resp_data !== '0) begin bad++; $display("FAIL abort_resp got=%b/%h want=00/0", bus.resp_valid, bus.resp_data); end
      total++; if ({mem_addr, mem_extra, mem_lower_bound, mem_upper_bound} !== '0)
         begin bad++; $display("FAIL abort_mem got=%h/%h/%h/%h want=0/0/0/0", mem_addr, mem_extra, mem_lower_bound, mem_upper_bound); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++; if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL abort_no_resp%0d got=%b want=00", i, bus.resp_valid); end
      end
      bus.req_valid = 2'b11;
      #1;
      total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL abort_next_grant got=%b want=01", bus.req_ready); end
      bus.req_valid = 2'b00;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_single();
      test_bounds();
      test_hold();
      test_latch();
      test_back_to_back();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
